// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_xcvr transceiver: parity encoding,
// TX/RX state enums and the configured data-bit count.
package uart_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      EVEN = 2'd1,
      ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

   function automatic logic [3:0] data_bit_count(input logic [1:0] cfg_data_bits);
      return 4'd5 + {2'b00, cfg_data_bits};
   endfunction

   // Encoding 3 is an alias for "no parity".
   function automatic parity_e decode_parity(input logic [1:0] cfg_parity);
      case (cfg_parity)
         2'd1:    return EVEN;
         2'd2:    return ODD;
         default: return NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: free-running counter 0..cfg_div, one-clock
// tick at the terminal count, so the tick period is cfg_div+1 clocks.
module uart_baud_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt;

   assign tick = (cnt == cfg_div);

   // Wrapping on >= keeps the counter sane if cfg_div shrinks below cnt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt >= cfg_div) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_xcvr.sv
// UART transceiver: programmable baud, 5-8 data bits, parity, 1/2 stop bits,
// majority-vote RX with parity/framing/break flags. Optional UART_XCVR_LOOPBACK_EN.
module uart_xcvr
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH  = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic [1:0]           cfg_data_bits,
   input  logic [1:0]           cfg_parity,
   input  logic                 cfg_stop2,
`ifdef UART_XCVR_LOOPBACK_EN
   input  logic                 loopback,
`endif
   input  logic [7:0]           tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_break,
   input  logic                 rx_uart,
   output logic                 tx_uart
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_PRE  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0] OS_POST = OS_W'(OVERSAMPLE / 2 + 1);

   logic tick;

   uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
      .clk     (clk),
      .reset   (reset),
      .cfg_div (cfg_div),
      .tick    (tick)
   );

   tx_state_e       tx_state, tx_state_nxt;
   logic [OS_W-1:0] tx_os;
   logic [2:0]      tx_idx;
   logic [3:0]      tx_nbits;
   parity_e         tx_par;
   logic            tx_stop2, tx_line, tx_bit_val, tx_par_bit;
   logic [7:0]      tx_shift, tx_mask;
   logic            tx_bit_end, tx_last_data;

   assign tx_mask      = 8'hFF >> (2'd3 - cfg_data_bits);
   assign tx_bit_end   = (tx_os == OS_LAST);
   assign tx_last_data = ({1'b0, tx_idx} == tx_nbits - 4'd1);
   assign tx_ready     = (tx_state == TX_IDLE) && !reset;

   always_comb begin
      tx_state_nxt = tx_state;
      tx_bit_val   = 1'b1;
      case (tx_state)
         TX_IDLE:   if (tx_valid) tx_state_nxt = TX_START;
         TX_START: begin
            tx_bit_val = 1'b0;
            if (tick && tx_bit_end) tx_state_nxt = TX_DATA;
         end
         TX_DATA: begin
            tx_bit_val = tx_shift[0];
            if (tick && tx_bit_end && tx_last_data)
               tx_state_nxt = (tx_par == NONE) ? TX_STOP : TX_PARITY;
         end
         TX_PARITY: begin
            tx_bit_val = tx_par_bit;
            if (tick && tx_bit_end) tx_state_nxt = TX_STOP;
         end
         TX_STOP:   if (tick && tx_bit_end && (tx_idx[0] == tx_stop2)) tx_state_nxt = TX_IDLE;
         default:   tx_state_nxt = TX_IDLE;
      endcase
   end

   // The line register loads on ticks only, so it trails the FSM by one tick;
   // this is what makes the start bit begin on the first tick after the handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_os    <= '0;
         tx_idx   <= '0;
         tx_line  <= 1'b1;
         tx_nbits <= 4'd8;
         tx_par   <= NONE;
         tx_stop2 <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt;
         if (tx_state == TX_IDLE) begin
            tx_os  <= '0;
            tx_idx <= '0;
            if (tx_valid) begin
               tx_nbits <= data_bit_count(cfg_data_bits);
               tx_par   <= decode_parity(cfg_parity);
               tx_stop2 <= cfg_stop2;
            end
         end else if (tick) begin
            tx_line <= tx_bit_val;
            if (tx_bit_end) begin
               tx_os  <= '0;
               tx_idx <= (tx_state_nxt != tx_state) ? 3'd0 : tx_idx + 3'd1;
            end else begin
               tx_os <= tx_os + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tx_state == TX_IDLE && tx_valid) begin
         tx_shift   <= tx_data & tx_mask;
         tx_par_bit <= ^(tx_data & tx_mask) ^ (decode_parity(cfg_parity) == ODD);
      end else if (tx_state == TX_DATA && tick && tx_bit_end) begin
         tx_shift <= tx_shift >> 1;
      end
   end

   logic rx_src;
`ifdef UART_XCVR_LOOPBACK_EN
   assign tx_uart = loopback ? 1'b1 : tx_line;
   assign rx_src  = loopback ? tx_line : rx_uart;
`else
   assign tx_uart = tx_line;
   assign rx_src  = rx_uart;
`endif

   rx_state_e       rx_state, rx_state_nxt;
   logic            rx_sync_p0, rx_sync_p1;
   logic [OS_W-1:0] rx_os;
   logic [2:0]      rx_idx;
   logic [3:0]      rx_nbits;
   parity_e         rx_par;
   logic [1:0]      rx_smp;
   logic [7:0]      rx_shift;
   logic            rx_zero, rx_par_acc, rx_par_bad;
   logic            rx_line, rx_maj, rx_bit_end, rx_decide, rx_last_data;

   assign rx_line      = rx_sync_p1;
   assign rx_maj       = (rx_smp[0] & rx_smp[1]) | (rx_line & (rx_smp[0] | rx_smp[1]));
   assign rx_bit_end   = tick && (rx_os == OS_LAST);
   assign rx_decide    = tick && (rx_os == OS_POST);
   assign rx_last_data = ({1'b0, rx_idx} == rx_nbits - 4'd1);

   always_comb begin
      rx_state_nxt = rx_state;
      case (rx_state)
         RX_IDLE:      if (!rx_line) rx_state_nxt = RX_START;
         RX_START: begin
            if (tick && rx_os == OS_MID && rx_line) rx_state_nxt = RX_IDLE;
            else if (rx_bit_end)                    rx_state_nxt = RX_DATA;
         end
         RX_DATA:      if (rx_bit_end && rx_last_data)
                          rx_state_nxt = (rx_par == NONE) ? RX_STOP : RX_PARITY;
         RX_PARITY:    if (rx_bit_end) rx_state_nxt = RX_STOP;
         RX_STOP:      if (rx_decide) rx_state_nxt = rx_maj ? RX_IDLE : RX_WAIT_IDLE;
         RX_WAIT_IDLE: if (rx_line) rx_state_nxt = RX_IDLE;
         default:      rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sync_p0    <= 1'b1;
         rx_sync_p1    <= 1'b1;
         rx_state      <= RX_IDLE;
         rx_os         <= '0;
         rx_idx        <= '0;
         rx_nbits      <= 4'd8;
         rx_par        <= NONE;
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_break      <= 1'b0;
      end else begin
         rx_sync_p0 <= rx_src;
         rx_sync_p1 <= rx_sync_p0;
         rx_state   <= rx_state_nxt;
         rx_valid   <= 1'b0;
         if (rx_state == RX_IDLE) begin
            rx_os  <= '0;
            rx_idx <= '0;
            if (!rx_line) begin
               rx_nbits <= data_bit_count(cfg_data_bits);
               rx_par   <= decode_parity(cfg_parity);
            end
         end else if (tick) begin
            rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + 1'b1;
            if (rx_os == OS_LAST)
               rx_idx <= (rx_state_nxt != rx_state) ? 3'd0 : rx_idx + 3'd1;
            if (rx_state == RX_STOP && rx_os == OS_POST) begin
               rx_valid      <= 1'b1;
               rx_data       <= rx_shift >> (4'd8 - rx_nbits);
               rx_parity_err <= rx_par_bad;
               rx_frame_err  <= ~rx_maj;
               rx_break      <= rx_zero & ~rx_maj;
            end
         end
      end
   end

   // Data bits enter at the MSB, so a short frame ends up left-aligned in rx_shift.
   always_ff @(posedge clk) begin
      if (rx_state == RX_IDLE) begin
         rx_zero    <= 1'b1;
         rx_par_acc <= 1'b0;
         rx_par_bad <= 1'b0;
      end else if (tick) begin
         if (rx_os == OS_PRE) rx_smp[0] <= rx_line;
         if (rx_os == OS_MID) rx_smp[1] <= rx_line;
         if (rx_os == OS_POST) begin
            if (rx_state == RX_DATA) begin
               rx_shift   <= {rx_maj, rx_shift[7:1]};
               rx_par_acc <= rx_par_acc ^ rx_maj;
               rx_zero    <= rx_zero & ~rx_maj;
            end else if (rx_state == RX_PARITY) begin
               rx_par_bad <= rx_maj != (rx_par_acc ^ (rx_par == ODD));
               rx_zero    <= rx_zero & ~rx_maj;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: TX line shape, TX->RX loop, RX error flags,
// false-start rejection and asynchronous reset during a frame.
`timescale 1ns/1ps
module tb_uart_xcvr;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] cfg_div = 16'd0;
   logic [1:0]  cfg_data_bits = 2'd3;
   logic [1:0]  cfg_parity = 2'd0;
   logic        cfg_stop2 = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_parity_err, rx_frame_err, rx_break;
   logic        rx_uart, tx_uart;
   logic        rx_drv = 1'b1;
   logic        lb_sel = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          rx_cnt = 0;
   logic [7:0]  rx_last_data = 8'h00;
   logic        rx_last_par = 1'b0, rx_last_frm = 1'b0, rx_last_brk = 1'b0;

   assign rx_uart = lb_sel ? tx_uart : rx_drv;

   always #5 clk = ~clk;

   uart_xcvr #(.DIV_WIDTH(16), .OVERSAMPLE(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_div       (cfg_div),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
`ifdef UART_XCVR_LOOPBACK_EN
      .loopback      (1'b0),
`endif
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rx_break      (rx_break),
      .rx_uart       (rx_uart),
      .tx_uart       (tx_uart)
   );

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt       <= rx_cnt + 1;
         rx_last_data <= rx_data;
         rx_last_par  <= rx_parity_err;
         rx_last_frm  <= rx_frame_err;
         rx_last_brk  <= rx_break;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Handshake one byte, then sample tx_uart mid-bit (clock 9+16*i after the
   // handshake edge) and count clocks until tx_ready returns.
   task automatic send_frame(input string tag, input logic [7:0] data, input int nb,
                             input logic [15:0] exp_bits, input bit cfg_swap);
      int k, bi, w;
      w = 0;
      @(negedge clk);
      while (!tx_ready && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_ready_wait"}, tx_ready, 1'b1);
      tx_data  = data;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      chk({tag, "_ready_drop"}, tx_ready, 1'b0);
      k  = 0;
      bi = 0;
      while (k < 2000) begin
         @(posedge clk);
         #1 k++;
         if (cfg_swap && k == 20) begin
            cfg_data_bits = 2'd3;
            cfg_parity    = 2'd0;
            cfg_stop2     = 1'b0;
         end
         if (bi < nb && k == 9 + 16 * bi) begin
            chk($sformatf("%s_bit%0d", tag, bi), tx_uart, exp_bits[bi]);
            bi++;
         end
         if (tx_ready) break;
      end
      chk({tag, "_busy_clks"}, k, nb * 16);
   endtask

   task automatic drive_rx(input logic [15:0] bits, input int nb);
      @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         rx_drv = bits[i];
         repeat (16) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic chk_rx(input string tag, input int exp_cnt, input logic [7:0] d,
                         input logic p, input logic f, input logic b);
      repeat (8) @(negedge clk);
      chk({tag, "_rx_cnt"}, rx_cnt, exp_cnt);
      chk({tag, "_rx_data"}, rx_last_data, d);
      chk({tag, "_rx_par"}, rx_last_par, p);
      chk({tag, "_rx_frm"}, rx_last_frm, f);
      chk({tag, "_rx_brk"}, rx_last_brk, b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx_uart", tx_uart, 1'b1);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_flags", {rx_parity_err, rx_frame_err, rx_break}, 3'b000);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", tx_ready, 1'b1);

      // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1 (bit i of the vector = i-th bit on the line)
      lb_sel = 1'b1;
      send_frame("a5", 8'hA5, 10, 16'h034A, 1'b0);
      chk_rx("a5", 1, 8'hA5, 1'b0, 1'b0, 1'b0);

      // 7E2 with bit 7 set in tx_data (ignored): line 0,1,0,0,0,0,0,1,0,1,1;
      // config is switched to 8N1 mid-frame and must not affect it.
      cfg_data_bits = 2'd2;
      cfg_parity    = 2'd1;
      cfg_stop2     = 1'b1;
      send_frame("e7", 8'hC1, 11, 16'h0682, 1'b1);
      chk_rx("e7", 2, 8'h41, 1'b0, 1'b0, 1'b0);

      // 8O1 0x5A driven on rx_uart: good parity (1), then corrupted parity (0)
      lb_sel     = 1'b0;
      cfg_parity = 2'd2;
      drive_rx(16'h06B4, 11);
      chk_rx("o8_good", 3, 8'h5A, 1'b0, 1'b0, 1'b0);
      drive_rx(16'h04B4, 11);
      chk_rx("o8_bad", 4, 8'h5A, 1'b1, 1'b0, 1'b0);

      // Break: 12 bit times low on 8N1
      cfg_parity = 2'd0;
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (180) @(negedge clk);
      chk("brk_cnt", rx_cnt, 5);
      chk("brk_data", rx_last_data, 8'h00);
      chk("brk_flag", rx_last_brk, 1'b1);
      chk("brk_frm", rx_last_frm, 1'b1);
      chk("brk_par", rx_last_par, 1'b0);
      repeat (12) @(negedge clk);
      chk("brk_hold_cnt", rx_cnt, 5);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
      chk("brk_idle_cnt", rx_cnt, 5);
      drive_rx(16'h0266, 10);
      chk_rx("after_brk", 6, 8'h33, 1'b0, 1'b0, 1'b0);

      // 5-clock glitch is a false start; the next real frame must still be received
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (5) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_cnt", rx_cnt, 6);
      drive_rx(16'h032C, 10);
      chk_rx("after_glitch", 7, 8'h96, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a looped 0x3C frame
      lb_sel = 1'b1;
      @(negedge clk);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("rst_mid_pre", tx_uart, 1'b0);
      reset = 1'b1;
      #1 chk("rst_mid_tx_uart", tx_uart, 1'b1);
      chk("rst_mid_tx_ready", tx_ready, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_mid_rx_cnt", rx_cnt, 7);
      send_frame("3c", 8'h3C, 10, 16'h0278, 1'b0);
      chk_rx("3c", 8, 8'h3C, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised UART transceiver core with a runtime-programmable baud divisor, 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, majority-vote RX sampling and per-frame error reporting (parity, framing, break). It replaces fixed baud-table controllers. It sits between the system clock domain's TX/RX AXI-Stream FIFOs and the `tx_uart`/`rx_uart` pins.

## Interface
- `DIV_WIDTH`, 16: width of the baud divisor.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_div` in `DIV_WIDTH`: tick period is `cfg_div+1` clocks. Set `cfg_div = Fclk/(OVERSAMPLE*baud) - 1`.
- `cfg_data_bits` in 2: data bits per frame = `5 + cfg_data_bits`.
- `cfg_parity` in 2: 0 none, 1 even, 2 odd, 3 none.
- `cfg_stop2` in 1: TX sends 2 stop bits when set.
- `tx_data` in 8: byte to send, LSB first; unused upper bits ignored.
- `tx_valid` in 1 / `tx_ready` out 1: valid/ready handshake.
- `rx_data` out 8: received byte, zero-extended.
- `rx_valid` out 1: one-cycle pulse; no backpressure.
- `rx_parity_err`, `rx_frame_err`, `rx_break` out 1 each: qualified by `rx_valid`.
- `rx_uart` in 1: serial input, asynchronous.
- `tx_uart` out 1: serial output.

## Operation
- Reset values: `tx_uart=1`, `tx_ready=0` while `reset` is asserted, `rx_valid=0`, all error flags 0, `rx_data=0`, both FSMs IDLE, tick counter 0, RX synchroniser flops 1.
- Baud tick generator:
  - Free-running counter from 0 to `cfg_div`, then wraps.
  - `tick` is high for one clock at `cnt==cfg_div`.
  - `cfg_div=0` gives a tick on every clock.
- Config latch:
  - TX latches `cfg_*` on the handshake.
  - RX latches `cfg_*` on start detect.
  - Mid-frame config changes do not affect the current frame.
- TX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - `tx_ready=1` only in IDLE; a handshake moves the FSM to START.
  - Each bit lasts exactly OVERSAMPLE ticks. DATA shifts `5+cfg_data_bits` bits, LSB first.
  - PARITY is skipped when parity is none. Even parity makes the total count of ones (data+parity) even; odd parity makes it odd.
  - STOP lasts 1 or 2 bit times.
- RX FSM states: IDLE → START → DATA → PARITY → STOP → (WAIT_IDLE) → IDLE.
  - `rx_uart` passes through a 2-flop synchroniser.
  - IDLE → START when the synchronised line is 0.
  - At tick OVERSAMPLE/2 of START, the line is checked. If it reads 1, the start is false: return to IDLE with no output.
  - Each bit value is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
  - RX checks exactly one stop bit.
  - At the stop-bit decision, pulse `rx_valid` and present `rx_data` and the flags.
    - `rx_frame_err`: stop bit = 0.
    - `rx_break`: all data, parity and stop bits = 0. `rx_frame_err` is also set.
    - `rx_parity_err`: parity mismatch; always 0 when parity is none.
  - After a frame error, go to WAIT_IDLE until the line is 1, then IDLE.
  - Otherwise return to IDLE immediately. This allows back-to-back frames with 1 stop bit.

## Timing
- TX handshake at clock N: `tx_ready` is 0 at N+1.
- `tx_uart` falls the clock after the first tick following N. Start-of-frame jitter is at most `cfg_div+1` clocks.
- Frame length: (1 + data bits + parity + stop bits) × OVERSAMPLE × (`cfg_div+1`) clocks.
- `tx_ready` returns to 1 the clock after the final stop tick. The next handshake may occur in that same cycle.
- RX latency: `rx_valid` is asserted 1 clock after the tick that completes the stop-bit majority sample. The synchroniser adds 2 clocks of input delay.
- Asynchronous reset mid-frame: `tx_uart=1` immediately; the partial RX frame is discarded with no `rx_valid`.

## Configuration
- `UART_XCVR_LOOPBACK_EN`: adds an input port `loopback` (1 bit).
  - With the macro and `loopback=1`: the RX synchroniser input is the internal TX serial line, and `tx_uart` is held at 1.
  - Without the macro: no port; RX always uses `rx_uart`.

## Structure
- `uart_pkg` holds:
  - `parity_e` (NONE, EVEN, ODD)
  - `tx_state_e`, `rx_state_e`
  - a helper function for the bit count
- Sub-module `uart_baud_gen` contains the tick counter. It takes `cfg_div` and outputs `tick`.
- The TX and RX FSMs live in `uart_xcvr`.

## Test plan
- `cfg_div=0`, OVERSAMPLE=16, 8N1, send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; `tx_ready` is low for 160 clocks.
- 7E2, send 0x41 → 7 data bits, parity bit 0, stop high for 32 clocks. Loop into RX → `rx_data=0x41`, no errors.
- 8O1 frame with corrupted parity → `rx_valid` with `rx_parity_err=1`, data intact.
- 12 bit-times of low on `rx_uart` → `rx_break=1`, `rx_frame_err=1`, `rx_data=0x00`. No second `rx_valid` until the line returns high and a new start is detected.
- A 5-clock low glitch (`cfg_div=0`) → no `rx_valid`; RX is back in IDLE.
- Assert `reset` mid-TX byte → `tx_uart=1` the same cycle. After release, a fresh 0x3C transmits correctly.
